// File: rtl/systolic_sequencer.sv
// Feed/drain controller for a systolic array: buffers operands, streams them
// diagonally skewed into the array, then drains one result row per cycle.
module systolic_sequencer #(
  parameter int ROW_NUMBER    = 4,
  parameter int COLUMN_NUMBER = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int K_DEPTH       = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_LAT     = 1,
  localparam int MAX_RC = (ROW_NUMBER > COLUMN_NUMBER) ? ROW_NUMBER : COLUMN_NUMBER,
  // one spare code on lane/index so out-of-range writes can be expressed and rejected
  localparam int LANE_W = $clog2(MAX_RC + 1),
  localparam int IDX_W  = $clog2(K_DEPTH + 1),
  localparam int ROW_W  = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic                                wr_sel,
  input  logic [LANE_W-1:0]                   wr_lane,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                wr_err,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                arr_reset,
  output logic                                arr_through,
  output logic [COLUMN_NUMBER*DATA_WIDTH-1:0] top_in,
  output logic [ROW_NUMBER*DATA_WIDTH-1:0]    left_in,
  input  logic [COLUMN_NUMBER*DATA_WIDTH-1:0] down_out,
  output logic                                res_valid,
  output logic [ROW_W-1:0]                    res_row,
  output logic [COLUMN_NUMBER*DATA_WIDTH-1:0] res_data,
  output logic [2:0]                          dbg_state
);

  localparam int F_LEN     = K_DEPTH + MAX_RC - 1;
  localparam int DRAIN_LEN = DRAIN_LAT + ROW_NUMBER;
  localparam int CNT_MAX   = (F_LEN > SETTLE_CYCLES) ?
                             ((F_LEN > DRAIN_LEN) ? F_LEN : DRAIN_LEN) :
                             ((SETTLE_CYCLES > DRAIN_LEN) ? SETTLE_CYCLES : DRAIN_LEN);
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int KI_W      = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_SETTLE, S_DRAIN, S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  int                            cnt_i;
  logic [DATA_WIDTH-1:0]         top_buf_q  [COLUMN_NUMBER][K_DEPTH];
  logic [DATA_WIDTH-1:0]         left_buf_q [ROW_NUMBER][K_DEPTH];
  logic                          wr_err_q;
  logic                          res_valid_q;
  logic [ROW_W-1:0]              res_row_q;
  logic [COLUMN_NUMBER*DATA_WIDTH-1:0] res_data_q;
  logic                          wr_ok;
  logic                          drain_sample;

  assign cnt_i     = int'(cnt_q);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: if (cnt_i == F_LEN - 1) begin
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES > 0) ? S_SETTLE : S_DRAIN;
      end
      S_SETTLE: if (cnt_i == SETTLE_CYCLES - 1) begin
        cnt_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: if (cnt_i == DRAIN_LEN - 1) begin
        cnt_d   = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Lane i is delayed by i cycles, giving the diagonal wavefront the array expects.
  always_comb begin
    int t_off;
    t_off       = 0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    arr_reset   = (state_q == S_IDLE) || (state_q == S_CLEAR);
    arr_through = (state_q == S_DRAIN);
    top_in      = '0;
    left_in     = '0;
    for (int i = 0; i < COLUMN_NUMBER; i++) begin
      t_off = cnt_i - i;
      if (state_q == S_FEED && t_off >= 0 && t_off < K_DEPTH)
        top_in[i*DATA_WIDTH +: DATA_WIDTH] = top_buf_q[i][t_off[KI_W-1:0]];
    end
    for (int j = 0; j < ROW_NUMBER; j++) begin
      t_off = cnt_i - j;
      if (state_q == S_FEED && t_off >= 0 && t_off < K_DEPTH)
        left_in[j*DATA_WIDTH +: DATA_WIDTH] = left_buf_q[j][t_off[KI_W-1:0]];
    end
  end

  assign wr_ok = wr_en && (state_q == S_IDLE) &&
                 (int'(wr_lane) < (wr_sel ? ROW_NUMBER : COLUMN_NUMBER)) &&
                 (int'(wr_idx) < K_DEPTH);
  assign drain_sample = (state_q == S_DRAIN) && (cnt_i >= DRAIN_LAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COLUMN_NUMBER; i++)
        for (int k = 0; k < K_DEPTH; k++) top_buf_q[i][k] <= '0;
      for (int j = 0; j < ROW_NUMBER; j++)
        for (int k = 0; k < K_DEPTH; k++) left_buf_q[j][k] <= '0;
      wr_err_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      res_data_q  <= '0;
    end else begin
      wr_err_q <= wr_en && !wr_ok;
      for (int i = 0; i < COLUMN_NUMBER; i++)
        for (int k = 0; k < K_DEPTH; k++)
          if (wr_ok && !wr_sel && int'(wr_lane) == i && int'(wr_idx) == k)
            top_buf_q[i][k] <= wr_data;
      for (int j = 0; j < ROW_NUMBER; j++)
        for (int k = 0; k < K_DEPTH; k++)
          if (wr_ok && wr_sel && int'(wr_lane) == j && int'(wr_idx) == k)
            left_buf_q[j][k] <= wr_data;
      // bottom row leaves the array first
      res_valid_q <= drain_sample;
      if (drain_sample) begin
        res_row_q  <= ROW_W'(ROW_NUMBER - 1 - (cnt_i - DRAIN_LAT));
        res_data_q <= down_out;
      end
    end
  end

  assign wr_err    = wr_err_q;
  assign res_valid = res_valid_q;
  assign res_row   = res_row_q;
  assign res_data  = res_data_q;

endmodule
